// File: rtl/boid_pkg.sv
// boid_pkg: shared types and default geometry for the boid sprite writer.
//   DEF_* constants : default screen/sprite/framebuffer geometry
//   fix16_t         : signed 16.16 fixed-point coordinate
//   pix_t           : signed integer pixel coordinate
//   writer_state_t  : sprite writer FSM states
//   fix_to_pix      : integer part of a 16.16 value (truncation toward -inf)
package boid_pkg;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_SPRITE   = 2;
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_COLOR_W  = 8;
  localparam int DEF_BG_COLOR = 0;

  typedef logic signed [31:0] fix16_t;
  typedef logic signed [15:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

  // Arithmetic shift keeps the sign, so negative values floor rather than
  // round toward zero.
  function automatic pix_t fix_to_pix(input fix16_t v);
    return pix_t'(v >>> 16);
  endfunction
endpackage

// File: rtl/boid_sprite_writer_pixel_addr_calc.sv
// pixel_addr_calc: combinational framebuffer address for one pixel.
//   i_col, i_row  : signed pixel coordinate
//   o_addr        : row*SCREEN_W + col (zero when out of bounds)
//   o_in_bounds   : pixel lies inside the visible screen
module pixel_addr_calc
  import boid_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  pix_t              i_col,
  input  pix_t              i_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_bounds
);
  localparam pix_t COL_LIM = pix_t'(SCREEN_W);
  localparam pix_t ROW_LIM = pix_t'(SCREEN_H);

  logic [ADDR_W-1:0] w_col_a;
  logic [ADDR_W-1:0] w_row_a;
  logic [ADDR_W-1:0] w_row_off;

  assign w_col_a = ADDR_W'($unsigned(i_col));
  assign w_row_a = ADDR_W'($unsigned(i_row));

  // 640 = 512 + 128, so the row offset is two shifts and an add.
  generate
    if (SCREEN_W == 640) begin : g_shift_mul
      assign w_row_off = (w_row_a << 4'd9) + (w_row_a << 4'd7);
    end else begin : g_gen_mul
      assign w_row_off = w_row_a * ADDR_W'(SCREEN_W);
    end
  endgenerate

  // Bounds test and address select; clipped pixels never produce an address.
  always_comb begin
    o_in_bounds = (i_col >= 16'sd0) && (i_col < COL_LIM) &&
                  (i_row >= 16'sd0) && (i_row < ROW_LIM);
    if (o_in_bounds) begin
      o_addr = w_row_off + w_col_a;
    end else begin
      o_addr = '0;
    end
  end
endmodule

// File: rtl/boid_sprite_writer.sv
// boid_sprite_writer: erases a boid's old sprite and draws the new one in the
// framebuffer through a granted write port.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start               : 1-cycle request, coordinates sampled this cycle
//   i_x, i_y, i_px, i_py  : new / previous position, signed 16.16
//   i_color               : draw color
//   i_mem_grant           : framebuffer port available this cycle
//   o_mem_we/addr/data    : framebuffer write request (registered)
//   o_busy                : sequence in progress
//   o_done                : 1-cycle pulse at sequence end
module boid_sprite_writer
  import boid_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPRITE   = DEF_SPRITE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int BG_COLOR = DEF_BG_COLOR
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic signed [31:0] i_x,
  input  logic signed [31:0] i_y,
  input  logic signed [31:0] i_px,
  input  logic signed [31:0] i_py,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_mem_grant,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [COLOR_W-1:0] o_mem_data,
  output logic               o_busy,
  output logic               o_done
);
  localparam int CNT_W = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPRITE - 1);

  writer_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_i, r_j, w_i_nxt, w_j_nxt;
  pix_t               r_x, r_y, r_px, r_py;
  pix_t               w_x_nxt, w_y_nxt, w_px_nxt, w_py_nxt;
  logic [COLOR_W-1:0] r_color, w_color_nxt, w_data_nxt;
  logic               r_mem_we, r_busy, r_done;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [COLOR_W-1:0] r_mem_data;
  logic               w_adv, w_we_nxt, w_in_bounds;
  pix_t               w_col, w_row;
  logic [ADDR_W-1:0]  w_addr;

  // Outputs are registered and always describe the pixel the FSM will be on
  // next cycle, so the address calc looks at next-state coordinates.
  pixel_addr_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .i_col       (w_col),
    .i_row       (w_row),
    .o_addr      (w_addr),
    .o_in_bounds (w_in_bounds)
  );

  // Next-state, counter and latch logic plus next-pixel selection.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_color_nxt = r_color;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_x_nxt     = fix_to_pix(i_x);
          w_y_nxt     = fix_to_pix(i_y);
          w_px_nxt    = fix_to_pix(i_px);
          w_py_nxt    = fix_to_pix(i_py);
          w_color_nxt = i_color;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          if ((w_px_nxt == w_x_nxt) && (w_py_nxt == w_y_nxt)) begin
            w_state_nxt = DRAW;
          end else begin
            w_state_nxt = ERASE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ERASE, DRAW: begin
        // A clipped pixel has mem_we low and steps without waiting for grant.
        w_adv = r_mem_we ? i_mem_grant : 1'b1;
        if (w_adv) begin
          if (r_i == LAST) begin
            w_i_nxt = '0;
            if (r_j == LAST) begin
              w_j_nxt     = '0;
              w_state_nxt = (r_state == ERASE) ? DRAW : DONE;
            end else begin
              w_j_nxt = r_j + 1'b1;
            end
          end else begin
            w_i_nxt = r_i + 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt == ERASE) begin
      w_col      = w_px_nxt + pix_t'(w_i_nxt);
      w_row      = w_py_nxt + pix_t'(w_j_nxt);
      w_data_nxt = COLOR_W'(BG_COLOR);
    end else begin
      w_col      = w_x_nxt + pix_t'(w_i_nxt);
      w_row      = w_y_nxt + pix_t'(w_j_nxt);
      w_data_nxt = w_color_nxt;
    end
    w_we_nxt = ((w_state_nxt == ERASE) || (w_state_nxt == DRAW)) && w_in_bounds;
  end

  // State, latches, counters and registered write port / status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_color    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_px     <= w_px_nxt;
      r_py     <= w_py_nxt;
      r_color  <= w_color_nxt;
      r_mem_we <= w_we_nxt;
      if (w_we_nxt) begin
        r_mem_addr <= w_addr;
        r_mem_data <= w_data_nxt;
      end
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
endmodule
